// File: rtl/seq_pipe_pkg.sv
// Shared types and constants for the two-entry skid buffer pipeline stage.
package seq_pipe_pkg;

    // Width of the occupancy output (counts 0..2).
    localparam int c_occ_w = 2;

    // Buffer occupancy states; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

    // Map a state to the number of buffered messages; unencoded states read as empty.
    function automatic logic [c_occ_w-1:0] occ_of(skid_state_t s);
        logic [c_occ_w-1:0] n;
        n = '0;
        case (s)
            ONE:     n = 2'd1;
            FULL:    n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/seq_pipe_skid_buf_if.sv
// Latency-insensitive val/rdy message channel.
// master drives val/msg and observes rdy; slave does the opposite.
interface seq_pipe_skid_buf_if #(
    parameter int p_nbits = 8
);
    logic               val;
    logic               rdy;
    logic [p_nbits-1:0] msg;

    modport master (output val, output msg, input rdy);
    modport slave  (input val, input msg, output rdy);
endinterface

// File: rtl/seq_pipe_en_reg.sv
// Parameterised data register with load enable and asynchronous active-high reset to zero.
module seq_pipe_en_reg #(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [p_nbits-1:0] d,
    output logic [p_nbits-1:0] q
);

    // Load only when enabled so the data flops toggle only on real transfers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/seq_pipe_skid_buf.sv
// Two-entry elastic pipeline stage. The head register drives the output; the
// skid register catches one extra message when the consumer stalls, so in_rdy
// depends only on registered state and never on the same-cycle out_rdy.
module seq_pipe_skid_buf
    import seq_pipe_pkg::*;
#(
    parameter int p_nbits = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    seq_pipe_skid_buf_if.slave      in_if,
    seq_pipe_skid_buf_if.master     out_if,
    output logic [c_occ_w-1:0]      occ
);

    skid_state_t        state;
    logic               in_rdy;
    logic               out_val;
    logic               in_fire;
    logic               out_fire;
    logic               main_en;
    logic               skid_en;
    logic [p_nbits-1:0] main_d;
    logic [p_nbits-1:0] main_q;
    logic [p_nbits-1:0] skid_q;

    // Handshake outputs come only from state; reset forces in_rdy low immediately.
    assign in_rdy   = (state != FULL) & ~reset;
    assign out_val  = (state == ONE) | (state == FULL);
    assign in_fire  = in_if.val & in_rdy;
    assign out_fire = out_val & out_if.rdy;

    assign in_if.rdy  = in_rdy;
    assign out_if.val = out_val;
    assign out_if.msg = main_q;
    assign occ        = occ_of(state);

    // Decide which data register loads this cycle and what the head takes in.
    always_comb begin
        main_en = 1'b0;
        skid_en = 1'b0;
        main_d  = in_if.msg;
        case (state)
            EMPTY: begin
                main_en = in_fire;
            end
            ONE: begin
                main_en = in_fire & out_fire;
                skid_en = in_fire & ~out_fire;
            end
            FULL: begin
                main_en = out_fire;
                main_d  = skid_q;
            end
            default: begin
                main_en = 1'b0;
            end
        endcase
    end

    // Occupancy FSM; any unencoded state falls back to EMPTY.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        state <= FULL;
                    end else if (!in_fire && out_fire) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state <= ONE;
                    end
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
        end
    end

    seq_pipe_en_reg #(.p_nbits(p_nbits)) main_reg (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    seq_pipe_en_reg #(.p_nbits(p_nbits)) skid_reg (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (in_if.msg),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_seq_pipe_skid_buf.sv
// Self-checking bench for the two-entry skid buffer, using a queue as the reference FIFO.
module tb_seq_pipe_skid_buf;
   import seq_pipe_pkg::*;

   logic clk;
   logic reset;
   logic [c_occ_w-1:0] occ;

   int checkCount;
   int errorCount;

   logic [7:0] model[$];

   seq_pipe_skid_buf_if #(.p_nbits(8)) inIf();
   seq_pipe_skid_buf_if #(.p_nbits(8)) outIf();

   seq_pipe_skid_buf #(.p_nbits(8)) dut (
      .clk    (clk),
      .reset  (reset),
      .in_if  (inIf),
      .out_if (outIf),
      .occ    (occ)
   );

   // 10 ns free-running clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
      end
   endtask

   // Drive producer and consumer inputs
   task automatic applyStimulus(input logic v, input logic [7:0] m, input logic r);
      inIf.val  = v;
      inIf.msg  = m;
      outIf.rdy = r;
   endtask

   // Compare DUT outputs against the reference FIFO contents
   task automatic compareModel(input string tag);
      checkOutput({tag, "_in_rdy"}, 32'(inIf.rdy), 32'(model.size() < 2));
      checkOutput({tag, "_out_val"}, 32'(outIf.val), 32'(model.size() > 0));
      checkOutput({tag, "_occ"}, 32'(occ), 32'(model.size()));
      if (model.size() > 0) begin
         checkOutput({tag, "_out_msg"}, 32'(outIf.msg), 32'(model[0]));
      end
   endtask

   // Advance one clock: transfers follow the pre-edge view of the FIFO, then outputs are checked
   task automatic cycle(input string tag);
      bit inF;
      bit outF;
      logic [7:0] tmp;
      inF  = inIf.val && (model.size() < 2) && !reset;
      outF = outIf.rdy && (model.size() > 0) && !reset;
      @(posedge clk);
      if (outF) begin
         tmp = model.pop_front();
      end
      if (inF) begin
         model.push_back(inIf.msg);
      end
      #1;
      compareModel(tag);
   endtask

   // Main stimulus sequence
   initial begin
      logic [7:0] counter;
      int staleSeen;
      bit pending;
      bit r;

      checkCount = 0;
      errorCount = 0;
      applyStimulus(1'b0, 8'h00, 1'b0);
      reset = 1'b1;

      // Reset held: handshake outputs must be low
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_in_rdy", 32'(inIf.rdy), 32'd0);
      checkOutput("rst_out_val", 32'(outIf.val), 32'd0);
      checkOutput("rst_occ", 32'(occ), 32'd0);
      #2 reset = 1'b0;
      #1;
      checkOutput("rel_in_rdy", 32'(inIf.rdy), 32'd1);

      // Idle after reset
      for (int i = 0; i < 3; i++) begin
         cycle("idle");
         checkOutput("idle_out_msg", 32'(outIf.msg), 32'h00);
      end

      // Streaming at full throughput
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 8'(i), 1'b1);
         cycle("stream");
         checkOutput("stream_msg", 32'(outIf.msg), 32'(i));
         checkOutput("stream_occ", 32'(occ), 32'd1);
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      cycle("drain");

      // Back-pressure fills both entries
      applyStimulus(1'b1, 8'hA1, 1'b0);
      cycle("bp1");
      applyStimulus(1'b1, 8'hA2, 1'b0);
      cycle("bp2");
      checkOutput("bp_full_occ", 32'(occ), 32'd2);
      checkOutput("bp_full_rdy", 32'(inIf.rdy), 32'd0);
      checkOutput("bp_full_msg", 32'(outIf.msg), 32'hA1);
      applyStimulus(1'b1, 8'hA3, 1'b0);
      cycle("bp3");
      checkOutput("bp_reject_occ", 32'(occ), 32'd2);
      applyStimulus(1'b1, 8'hA3, 1'b1);
      cycle("bp_rel1");
      checkOutput("bp_rel1_msg", 32'(outIf.msg), 32'hA2);
      cycle("bp_rel2");
      checkOutput("bp_rel2_msg", 32'(outIf.msg), 32'hA3);
      applyStimulus(1'b0, 8'h00, 1'b1);
      cycle("bp_rel3");
      checkOutput("bp_empty_val", 32'(outIf.val), 32'd0);

      // Simultaneous accept and release while holding one message
      applyStimulus(1'b1, 8'h55, 1'b0);
      cycle("sim_load");
      checkOutput("sim_hold_msg", 32'(outIf.msg), 32'h55);
      applyStimulus(1'b1, 8'h66, 1'b1);
      cycle("sim_both");
      checkOutput("sim_msg", 32'(outIf.msg), 32'h66);
      checkOutput("sim_occ", 32'(occ), 32'd1);
      applyStimulus(1'b0, 8'h00, 1'b1);
      cycle("sim_drain");

      // Random valid/ready with counting data; producer holds its message until accepted
      counter = 8'h00;
      pending = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (!pending) begin
            pending = ($urandom_range(0, 99) < 60);
         end
         r = ($urandom_range(0, 99) < 50);
         applyStimulus(pending, counter, ~r);
         #1;
         checkOutput("rnd_rdy_indep_a", 32'(inIf.rdy), 32'(model.size() < 2));
         outIf.rdy = r;
         #1;
         checkOutput("rnd_rdy_indep_b", 32'(inIf.rdy), 32'(model.size() < 2));
         if (pending && (model.size() < 2)) begin
            pending = 1'b0;
            counter = counter + 8'd1;
         end
         cycle("rnd");
      end
      applyStimulus(1'b0, 8'h00, 1'b1);
      cycle("rnd_drain1");
      cycle("rnd_drain2");

      // Mid-operation reset with both entries full
      applyStimulus(1'b1, 8'hC1, 1'b0);
      cycle("mr1");
      applyStimulus(1'b1, 8'hC2, 1'b0);
      cycle("mr2");
      checkOutput("mr_full_occ", 32'(occ), 32'd2);
      applyStimulus(1'b0, 8'h00, 1'b0);
      #2 reset = 1'b1;
      #1;
      checkOutput("mr_out_val", 32'(outIf.val), 32'd0);
      checkOutput("mr_in_rdy", 32'(inIf.rdy), 32'd0);
      checkOutput("mr_occ", 32'(occ), 32'd0);
      checkOutput("mr_out_msg", 32'(outIf.msg), 32'h00);
      model.delete();
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      compareModel("mr_rel");
      staleSeen = 0;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, 8'hD0 + 8'(i), 1'b1);
         cycle("mr_post");
         if (outIf.val && (outIf.msg == 8'hC1 || outIf.msg == 8'hC2)) begin
            staleSeen++;
         end
      end
      checkOutput("mr_stale", 32'(staleSeen), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      errorCount++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/seq_pipe_skid_buf.md
Name: seq_pipe_skid_buf

Overview:
- Two-entry elastic pipeline stage with a latency-insensitive val/rdy interface on both sides.
- Sits directly upstream of the fixed 1-cycle delay stages. It absorbs downstream back-pressure so the producer sees a ready that does not depend combinationally on out_rdy.
- Sustains one transfer per cycle with 1-cycle latency.
- Exposes current occupancy for debug and perf counters.

Parameters:
- p_nbits, 8, message width in bits (minimum 1)

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-high reset
- in_val  input  1  producer has a valid message on in_msg
- in_rdy  output  1  stage can accept a message this cycle
- in_msg  input  p_nbits  producer message
- out_val  output  1  out_msg holds a valid message
- out_rdy  input  1  consumer accepts out_msg this cycle
- out_msg  output  p_nbits  oldest buffered message
- occ  output  2  number of buffered messages (0..2)

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Transfer definitions: in_fire = in_val & in_rdy; out_fire = out_val & out_rdy.
- Storage: main register (head, drives out_msg) and skid register. State enum: EMPTY, ONE, FULL.
- Outputs are a pure function of state and registers, with no combinational path from inputs:
  - out_val = (state != EMPTY)
  - in_rdy = (state != FULL) & !reset
  - occ = 0 / 1 / 2 for EMPTY / ONE / FULL
  - out_msg = main register
- Reset values: state=EMPTY, main=0, skid=0, hence out_val=0, occ=0, out_msg=0. in_rdy is 0 while reset is high and 1 in the first cycle after deassertion.
- Transitions (posedge clk, reset low):
  - EMPTY: in_fire -> ONE, main<=in_msg; otherwise stay.
  - ONE, in_fire & out_fire -> ONE, main<=in_msg (full throughput).
  - ONE, in_fire only -> FULL, skid<=in_msg, main unchanged.
  - ONE, out_fire only -> EMPTY; main keeps its stale value, which is not observable because out_val=0.
  - ONE, neither -> stay.
  - FULL: in_rdy=0, so in_fire is impossible. out_fire -> ONE, main<=skid; otherwise stay.
- Latency: message accepted at edge N is presented on out_msg with out_val=1 in cycle N+1 if the buffer was empty.
- Ordering: strictly FIFO; no message is dropped or duplicated.
- in_val asserted while in_rdy=0: ignored, with no state change. The producer must hold in_val/in_msg stable until in_fire (protocol rule; a bench assertion, not RTL-checked).
- out_val is never deasserted without out_fire, except by reset.
- Reset mid-operation: contents are discarded immediately (asynchronous), and out_val and in_rdy drop in the same cycle reset rises. No transfer completes on an edge where reset is high.
- Data registers are updated only on their enable conditions above, to save power.
- occ must never exceed 2. Illegal or unencoded state recovers to EMPTY.

Decomposition:
- Shared package seq_pipe_pkg:
  - skid_state_t enum (EMPTY=2'd0, ONE=2'd1, FULL=2'd2)
  - localparam for the occupancy width
- One sub-module, seq_pipe_en_reg:
  - parameterized p_nbits register with enable and asynchronous active-high reset to 0
  - instantiated twice (main, skid)
- The FSM stays in the top module.

Test Plan:
- Reset then idle: after reset release, out_val=0, in_rdy=1, occ=0, out_msg=8'h00 for 3 cycles.
- Streaming: out_rdy=1 and send 8'h01..8'h08 back-to-back. Each value appears exactly one cycle after acceptance, in_rdy stays 1, occ stays 1.
- Back-pressure: out_rdy=0 and send 8'hA1, 8'hA2.
  - After the second accept: occ=2, in_rdy=0, out_msg=8'hA1.
  - Presenting 8'hA3 is not accepted.
  - Raise out_rdy: the outputs are 8'hA1, 8'hA2, then 8'hA3 (accepted once in_rdy=1), in order.
- Simultaneous in/out in ONE: hold 8'h55 in the buffer, then in the same cycle in_val with 8'h66 and out_rdy=1. Next cycle out_msg=8'h66, occ=1.
- Random valid/ready: random in_val/out_rdy for 1000 cycles with counting data. A scoreboard sees an in-order, lossless sequence, occ ≤ 2, and in_rdy never depends on same-cycle out_rdy.
- Mid-operation reset: with occ=2 (8'hC1, 8'hC2), assert reset between edges. out_val and in_rdy go to 0 immediately, occ=0. After release, 8'hC1 and 8'hC2 never appear.
